ysyx_210247_trap_unit: RTL and testbench

Machine-mode trap/CSR unit that consumes the CLINT timer interrupt (time_int) and supplies the mstatus/mie values the CLINT uses for gating.
- Owns mstatus, mie, mip, mtvec, mepc and mcause.
- Sequences traps (ecall, timer interrupt) and mret at the commit boundary.
- Issues a registered pipeline flush plus PC redirect to fetch.

---
 rtl/ysyx_210247_trap_unit.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_210247_trap_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210247_trap_unit.sv
// -----------------------------------------------------------------------------
// ysyx_210247_trap_unit
//
// Machine-mode trap/CSR unit. Holds mstatus, mie, mip, mtvec, mepc and mcause,
// sequences ecall / timer-interrupt traps and mret at the commit boundary, and
// issues a one-cycle registered flush plus PC redirect to fetch.
//
// Optional feature (compile-time macro): TRAP_VECTORED_EN
//   defined   : mtvec[1:0] holds 00 or 01 (a write of 1x stores 00); in mode 01
//               interrupts vector to base+28, exceptions still go to base.
//   undefined : mtvec[1:0] is hardwired to 00, direct mode only.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   commit_valid    instruction retiring this cycle
//   commit_pc       PC of the retiring instruction
//   commit_next_pc  successor / branch target of the retiring instruction
//   commit_ecall    retiring instruction is ecall
//   commit_mret     retiring instruction is mret
//   time_int        CLINT timer interrupt (already gated by MIE/MTIE)
//   mem_busy        AXI data transaction outstanding
//   csr_raddr       CSR read address
//   csr_rdata       combinational CSR read data
//   csr_wen         CSR write strobe
//   csr_waddr       CSR write address
//   csr_wdata       CSR write data (already merged for csrrs/csrrc)
//   mstatus_o       mstatus to CLINT
//   mie_o           mie to CLINT
//   hold_o          stall commit while an interrupt is pending
//   flush_o         flush IF..MEM
//   redirect_valid  fetch redirect strobe
//   redirect_pc     redirect target
// -----------------------------------------------------------------------------
module ysyx_210247_trap_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_next_pc,
    input  logic            commit_ecall,
    input  logic            commit_mret,
    input  logic            time_int,
    input  logic            mem_busy,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            csr_wen,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mie_o,
    output logic            hold_o,
    output logic            flush_o,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;

    localparam logic [XLEN-1:0] MSTATUS_RESET = XLEN'(64'h1800);
    localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_TIMER   = {1'b1, {(XLEN-4){1'b0}}, 3'd7};
    localparam logic [XLEN-1:0] VEC_OFFSET    = XLEN'(28);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [XLEN-1:0] mstatus_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic            mip_q;
    logic [XLEN-1:0] target_q;

    logic            int_req;
    logic            take_ecall;
    logic            take_mret;
    logic            take_irq;
    logic            trap_enter;

    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] irq_target;
    logic [XLEN-1:0] mstatus_trap;
    logic [XLEN-1:0] mstatus_mret;
    logic [XLEN-1:0] mtvec_legal;
    logic [XLEN-1:0] mip_val;

    logic            wr_mstatus;
    logic            wr_mie;
    logic            wr_mtvec;
    logic            wr_mepc;
    logic            wr_mcause;

    // CSR write legalisation for mtvec: low two bits carry the mode.
    function automatic logic [XLEN-1:0] legal_mtvec(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
`ifdef TRAP_VECTORED_EN
        if (v[1]) begin
            r[1:0] = 2'b00;
        end
`else
        r[1:0] = 2'b00;
`endif
        return r;
    endfunction

    // Internal MIE re-qualifies the interrupt so that it cannot be re-taken
    // in the cycles after a trap clears MIE, before the CLINT gating catches up.
    assign int_req = time_int & mstatus_q[BIT_MIE];

    assign trap_base   = mtvec_q & ~XLEN'(3);
    assign mtvec_legal = legal_mtvec(csr_wdata);
    assign mip_val     = XLEN'({mip_q, 7'b0});

`ifdef TRAP_VECTORED_EN
    assign irq_target = (mtvec_q[1:0] == 2'b01) ? (trap_base + VEC_OFFSET) : trap_base;
`else
    assign irq_target = trap_base;
`endif

    // Commit event decode. ecall beats mret beats the pending interrupt;
    // a commit arriving while the redirect is being issued is ignored.
    always_comb begin
        take_ecall = 1'b0;
        take_mret  = 1'b0;
        take_irq   = 1'b0;
        if (state_q != REDIR && commit_valid) begin
            if (commit_ecall) begin
                take_ecall = 1'b1;
            end else if (commit_mret) begin
                take_mret = 1'b1;
            end else if (state_q == PEND && int_req && !mem_busy) begin
                take_irq = 1'b1;
            end
        end
    end

    assign trap_enter = take_ecall | take_irq;

    always_comb begin
        mstatus_trap                = mstatus_q;
        mstatus_trap[BIT_MPIE]      = mstatus_q[BIT_MIE];
        mstatus_trap[BIT_MIE]       = 1'b0;
        mstatus_trap[12:11]         = 2'b11;
    end

    always_comb begin
        mstatus_mret                = mstatus_q;
        mstatus_mret[BIT_MIE]       = mstatus_q[BIT_MPIE];
        mstatus_mret[BIT_MPIE]      = 1'b1;
    end

    assign wr_mstatus = csr_wen && (csr_waddr == ADDR_MSTATUS);
    assign wr_mie     = csr_wen && (csr_waddr == ADDR_MIE);
    assign wr_mtvec   = csr_wen && (csr_waddr == ADDR_MTVEC);
    assign wr_mepc    = csr_wen && (csr_waddr == ADDR_MEPC);
    assign wr_mcause  = csr_wen && (csr_waddr == ADDR_MCAUSE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_ecall || take_mret) begin
                    state_d = REDIR;
                end else if (int_req) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (take_ecall || take_mret || take_irq) begin
                    state_d = REDIR;
                end else if (!int_req) begin
                    state_d = IDLE;
                end
            end
            REDIR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs; redirect_pc is forced to 0 outside the redirect cycle so the
    // target latch needs no reset.
    always_comb begin
        hold_o         = 1'b0;
        flush_o        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            PEND: begin
                hold_o = 1'b1;
            end
            REDIR: begin
                flush_o        = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: begin
            end
        endcase
    end

    // Redirect target, latched at the qualifying commit.
    always_ff @(posedge clk) begin
        if (take_ecall) begin
            target_q <= trap_base;
        end else if (take_mret) begin
            target_q <= mepc_q;
        end else if (take_irq) begin
            target_q <= irq_target;
        end
    end

    // CSR state. Trap/mret updates take precedence over a software write to
    // the same register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q <= MSTATUS_RESET;
            mie_q     <= '0;
            mtvec_q   <= legal_mtvec(MTVEC_RESET);
            mepc_q    <= '0;
            mcause_q  <= '0;
            mip_q     <= 1'b0;
        end else begin
            mip_q <= time_int;

            if (trap_enter) begin
                mstatus_q <= mstatus_trap;
            end else if (take_mret) begin
                mstatus_q <= mstatus_mret;
            end else if (wr_mstatus) begin
                mstatus_q <= csr_wdata;
            end

            if (wr_mie) begin
                mie_q <= csr_wdata;
            end

            if (wr_mtvec) begin
                mtvec_q <= mtvec_legal;
            end

            if (take_ecall) begin
                mepc_q <= commit_pc;
            end else if (take_irq) begin
                mepc_q <= commit_next_pc;
            end else if (wr_mepc) begin
                mepc_q <= csr_wdata & ~XLEN'(3);
            end

            if (take_ecall) begin
                mcause_q <= CAUSE_ECALL;
            end else if (take_irq) begin
                mcause_q <= CAUSE_TIMER;
            end else if (wr_mcause) begin
                mcause_q <= csr_wdata;
            end
        end
    end

    // Combinational CSR read port; unmapped addresses read as zero.
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            ADDR_MSTATUS: csr_rdata = mstatus_q;
            ADDR_MIE:     csr_rdata = mie_q;
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
            ADDR_MIP:     csr_rdata = mip_val;
            default:      csr_rdata = '0;
        endcase
    end

    assign mstatus_o = mstatus_q;
    assign mie_o     = mie_q;

endmodule

// File: tb/tb_ysyx_210247_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_ysyx_210247_trap_unit
//
// Directed bench for ysyx_210247_trap_unit. A behavioural model of the trap
// rules is stepped at every rising edge from the driver, and a negedge process
// compares all outputs against it; hand-computed literals pin the scenarios.
// Honours TRAP_VECTORED_EN when defined.
// -----------------------------------------------------------------------------
module tb_ysyx_210247_trap_unit;

    localparam logic [63:0] MTVEC_RST = 64'h0;
    localparam logic [63:0] CAUSE_TMR = 64'h8000_0000_0000_0007;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] commit_next_pc;
    logic        commit_ecall;
    logic        commit_mret;
    logic        time_int;
    logic        mem_busy;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic [63:0] mstatus_o;
    logic [63:0] mie_o;
    logic        hold_o;
    logic        flush_o;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ysyx_210247_trap_unit #(
        .XLEN        (64),
        .MTVEC_RESET (MTVEC_RST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_next_pc (commit_next_pc),
        .commit_ecall   (commit_ecall),
        .commit_mret    (commit_mret),
        .time_int       (time_int),
        .mem_busy       (mem_busy),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .csr_wen        (csr_wen),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .mstatus_o      (mstatus_o),
        .mie_o          (mie_o),
        .hold_o         (hold_o),
        .flush_o        (flush_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_target;
    logic        m_mip7, m_pending, m_redir;
    logic        model_ok = 1'b0;

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip7 ? 64'h80 : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [63:0] old_ms, old_tv, old_epc, base;
        logic        e, r, i, mie_b;
        if (rst) begin
            m_mstatus = 64'h1800;
            m_mie     = 0;
            m_mtvec   = MTVEC_RST;
            m_mepc    = 0;
            m_mcause  = 0;
            m_mip7    = 0;
            m_pending = 0;
            m_redir   = 0;
            m_target  = 0;
            model_ok  = 1'b1;
            return;
        end
        old_ms  = m_mstatus;
        old_tv  = m_mtvec;
        old_epc = m_mepc;
        mie_b   = old_ms[3];
        e = !m_redir && commit_valid && commit_ecall;
        r = !m_redir && commit_valid && commit_mret && !commit_ecall;
        i = m_pending && time_int && mie_b && commit_valid && !mem_busy
            && !commit_ecall && !commit_mret;
        if (csr_wen) begin
            case (csr_waddr)
                12'h300: m_mstatus = csr_wdata;
                12'h304: m_mie     = csr_wdata;
                12'h305: begin
`ifdef TRAP_VECTORED_EN
                    m_mtvec = csr_wdata;
                    if (csr_wdata[1]) m_mtvec[1:0] = 2'b00;
`else
                    m_mtvec = csr_wdata & ~64'h3;
`endif
                end
                12'h341: m_mepc   = csr_wdata & ~64'h3;
                12'h342: m_mcause = csr_wdata;
                default: ;
            endcase
        end
        base = old_tv & ~64'h3;
        if (e || i) begin
            m_mstatus        = old_ms;
            m_mstatus[7]     = old_ms[3];
            m_mstatus[3]     = 1'b0;
            m_mstatus[12:11] = 2'b11;
            m_mepc           = e ? commit_pc : commit_next_pc;
            m_mcause         = e ? 64'd11 : CAUSE_TMR;
        end
        if (r) begin
            m_mstatus    = old_ms;
            m_mstatus[3] = old_ms[7];
            m_mstatus[7] = 1'b1;
        end
        if (e) m_target = base;
        if (r) m_target = old_epc;
        if (i) begin
            m_target = base;
`ifdef TRAP_VECTORED_EN
            if (old_tv[1:0] == 2'b01) m_target = base + 64'd28;
`endif
        end
        m_pending = !(e || r || i) && !m_redir && time_int && mie_b;
        m_redir   = e || r || i;
        m_mip7    = time_int;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            check("flush_o",        {63'b0, flush_o},        {63'b0, m_redir});
            check("redirect_valid", {63'b0, redirect_valid}, {63'b0, m_redir});
            check("hold_o",         {63'b0, hold_o},         {63'b0, m_pending});
            check("mstatus_o",      mstatus_o,               m_mstatus);
            check("mie_o",          mie_o,                   m_mie);
            check("csr_rdata",      csr_rdata,               m_read(csr_raddr));
            if (m_redir) check("redirect_pc", redirect_pc, m_target);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        csr_wen = 1'b1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_wen = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [63:0] exp);
        csr_raddr = a;
        tick();
        check(name, csr_rdata, exp);
    endtask

    task automatic commit(input logic [63:0] pc, input logic [63:0] npc,
                          input logic ec, input logic mr);
        commit_valid = 1'b1; commit_pc = pc; commit_next_pc = npc;
        commit_ecall = ec; commit_mret = mr;
    endtask

    task automatic commit_clear();
        commit_valid = 1'b0; commit_ecall = 1'b0; commit_mret = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        commit_clear();
        commit_pc = 0; commit_next_pc = 0;
        time_int = 0; mem_busy = 0;
        csr_raddr = 12'h300; csr_wen = 0; csr_waddr = 0; csr_wdata = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_flush",  {63'b0, flush_o},        64'd0);
        check("rst_redir",  {63'b0, redirect_valid}, 64'd0);
        check("rst_hold",   {63'b0, hold_o},         64'd0);
        check("rst_rpc",    redirect_pc,             64'd0);
        read_check("rst_mstatus", 12'h300, 64'h1800);
        read_check("rst_mtvec",   12'h305, MTVEC_RST);
        read_check("rst_mip",     12'h344, 64'h0);

        // Ecall
        csr_write(12'h305, 64'h8000_0100);
        csr_write(12'h300, 64'h1808);
        commit(64'h8000_0040, 64'h8000_0044, 1'b1, 1'b0);
        tick();
        commit_clear();
        check("ecall_redir", {63'b0, redirect_valid}, 64'd1);
        check("ecall_flush", {63'b0, flush_o},        64'd1);
        check("ecall_rpc",   redirect_pc,             64'h8000_0100);
        tick();
        check("ecall_redir_done", {63'b0, redirect_valid}, 64'd0);
        read_check("ecall_mepc",    12'h341, 64'h8000_0040);
        read_check("ecall_mcause",  12'h342, 64'd11);
        read_check("ecall_mstatus", 12'h300, 64'h1880);

        // Timer interrupt held off by mem_busy
        csr_write(12'h300, 64'h1808);
        time_int = 1; mem_busy = 1;
        tick();
        check("tmr_hold1", {63'b0, hold_o}, 64'd1);
        tick();
        check("tmr_hold2", {63'b0, hold_o}, 64'd1);
        read_check("tmr_mip", 12'h344, 64'h80);
        check("tmr_hold3", {63'b0, hold_o}, 64'd1);
        mem_busy = 0;
        commit(64'h8000_0200, 64'h8000_0204, 1'b0, 1'b0);
        tick();
        commit_clear();
        time_int = 0;
        check("tmr_redir", {63'b0, redirect_valid}, 64'd1);
        check("tmr_rpc",   redirect_pc,             64'h8000_0100);
        tick();
        read_check("tmr_mepc",    12'h341, 64'h8000_0204);
        read_check("tmr_mcause",  12'h342, CAUSE_TMR);
        read_check("tmr_mstatus", 12'h300, 64'h1880);

        // Mret
        commit(64'h8000_0100, 64'h8000_0104, 1'b0, 1'b1);
        tick();
        commit_clear();
        check("mret_redir", {63'b0, redirect_valid}, 64'd1);
        check("mret_rpc",   redirect_pc,             64'h8000_0204);
        tick();
        read_check("mret_mstatus", 12'h300, 64'h1888);

        // Collision: ecall + time_int + mepc write in one cycle
        commit(64'h8000_0300, 64'h8000_0304, 1'b1, 1'b0);
        time_int = 1;
        csr_wen = 1; csr_waddr = 12'h341; csr_wdata = 64'hDEAD_BEE0;
        tick();
        commit_clear();
        csr_wen = 0;
        check("col_rpc", redirect_pc, 64'h8000_0100);
        tick();
        check("col_hold1",  {63'b0, hold_o},         64'd0);
        check("col_redir1", {63'b0, redirect_valid}, 64'd0);
        tick();
        check("col_hold2",  {63'b0, hold_o},         64'd0);
        read_check("col_mepc",   12'h341, 64'h8000_0300);
        read_check("col_mcause", 12'h342, 64'd11);
        time_int = 0;
        read_check("col_mstatus", 12'h300, 64'h1880);

        // Interrupt withdrawn while pending
        csr_write(12'h300, 64'h1808);
        time_int = 1;
        tick();
        check("drop_hold", {63'b0, hold_o}, 64'd1);
        time_int = 0;
        tick();
        check("drop_hold_off", {63'b0, hold_o},         64'd0);
        check("drop_no_redir", {63'b0, redirect_valid}, 64'd0);
        tick();
        check("drop_no_redir2", {63'b0, redirect_valid}, 64'd0);

        // Write legalisation and unmapped addresses
        csr_write(12'h341, 64'h8000_0207);
        read_check("mepc_align", 12'h341, 64'h8000_0204);
        csr_write(12'h7C0, 64'h1234);
        read_check("unmapped", 12'h7C0, 64'h0);
        csr_write(12'h344, 64'hFF);
        read_check("mip_ro", 12'h344, 64'h0);
        csr_write(12'h304, 64'h80);
        read_check("mie_rw", 12'h304, 64'h80);
        check("mie_o", mie_o, 64'h80);
        csr_write(12'h305, 64'h8000_0103);
        read_check("mtvec_1x", 12'h305, 64'h8000_0100);
        csr_write(12'h305, 64'h8000_0101);
`ifdef TRAP_VECTORED_EN
        read_check("mtvec_01", 12'h305, 64'h8000_0101);
`else
        read_check("mtvec_01", 12'h305, 64'h8000_0100);
`endif

        // Timer trap target (vectored when enabled), then ecall to base
        commit(64'h8000_0400, 64'h8000_0404, 1'b0, 1'b0);
        time_int = 1;
        tick();
        check("vec_hold", {63'b0, hold_o}, 64'd1);
        tick();
        commit_clear();
        time_int = 0;
        check("vec_redir", {63'b0, redirect_valid}, 64'd1);
`ifdef TRAP_VECTORED_EN
        check("vec_rpc", redirect_pc, 64'h8000_011C);
`else
        check("vec_rpc", redirect_pc, 64'h8000_0100);
`endif
        tick();
        read_check("vec_mepc", 12'h341, 64'h8000_0404);
        commit(64'h8000_0500, 64'h8000_0504, 1'b1, 1'b0);
        tick();
        commit_clear();
        check("vec_ecall_rpc", redirect_pc, 64'h8000_0100);
        tick();

        // Reset while pending
        csr_write(12'h300, 64'h1808);
        time_int = 1;
        tick();
        check("rp_hold", {63'b0, hold_o}, 64'd1);
        rst = 1;
        tick();
        check("rp_hold_rst", {63'b0, hold_o}, 64'd0);
        rst = 0;
        time_int = 0;
        tick();
        check("rp_hold_after", {63'b0, hold_o}, 64'd0);
        read_check("rp_mstatus", 12'h300, 64'h1800);
        read_check("rp_mtvec",   12'h305, MTVEC_RST);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
